// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with req/ack memory handshake, one-entry skid buffer
// and redirect handling that discards a wrong-path fetch already issued to memory.
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [5:0]  if_op,
    output logic [4:0]  if_rs,
    output logic [4:0]  if_rt,
    output logic [4:0]  if_rd,
    output logic [15:0] if_imm
);
    typedef enum logic [1:0] {BOOT, REQ, KILL, FULL} state_t;
    state_t      r_state, w_state;
    logic [31:0] r_fa, w_fa, r_pend, w_pend;
    logic [31:0] r_skid_instr, w_skid_instr, r_skid_pc, w_skid_pc;
    logic [31:0] r_pc, w_pc, r_instr, w_instr;
    logic        r_valid, w_valid;
    logic [31:0] w_rpc, w_fa_inc;
    logic        w_slot_free;
    assign w_rpc       = {redirect_pc[31:2], 2'b00};
    assign w_fa_inc    = r_fa + 32'd4;
    assign w_slot_free = !r_valid || !stall;
    assign imem_req  = (r_state == REQ) || (r_state == KILL);
    assign imem_addr = r_fa;
    assign if_valid  = r_valid;
    assign if_pc     = r_pc;
    assign if_instr  = r_instr;
    assign if_op     = r_instr[31:26];
    assign if_rs     = r_instr[25:21];
    assign if_rt     = r_instr[20:16];
    assign if_rd     = r_instr[15:11];
    assign if_imm    = r_instr[15:0];
    // Redirect wins in every state and always empties the output slot.
    always_comb begin
        w_state      = r_state;
        w_fa         = r_fa;
        w_pend       = r_pend;
        w_skid_instr = r_skid_instr;
        w_skid_pc    = r_skid_pc;
        w_pc         = r_pc;
        w_instr      = r_instr;
        w_valid      = redirect ? 1'b0 : (r_valid && stall);
        case (r_state)
            BOOT: begin
                w_state = REQ;
                w_fa    = redirect ? w_rpc : r_fa;
            end
            REQ: begin
                if (redirect) begin
                    w_fa    = imem_ack ? w_rpc : r_fa;
                    w_pend  = imem_ack ? r_pend : w_rpc;
                    w_state = imem_ack ? REQ : KILL;
                end else if (imem_ack && w_slot_free) begin
                    w_pc    = r_fa;
                    w_instr = imem_rdata;
                    w_valid = 1'b1;
                    w_fa    = w_fa_inc;
                end else if (imem_ack) begin
                    w_skid_pc    = r_fa;
                    w_skid_instr = imem_rdata;
                    w_fa         = w_fa_inc;
                    w_state      = FULL;
                end
            end
            KILL: begin
                if (imem_ack) begin
                    w_fa    = redirect ? w_rpc : r_pend;
                    w_state = REQ;
                end else if (redirect) begin
                    w_pend = w_rpc;
                end
            end
            FULL: begin
                if (redirect) begin
                    w_fa    = w_rpc;
                    w_state = REQ;
                end else if (!stall) begin
                    w_pc    = r_skid_pc;
                    w_instr = r_skid_instr;
                    w_valid = 1'b1;
                    w_state = REQ;
                end
            end
            default: w_state = BOOT;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= BOOT;
            r_fa         <= PC_RESET;
            r_pend       <= '0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
            r_pc         <= '0;
            r_instr      <= '0;
            r_valid      <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_fa         <= w_fa;
            r_pend       <= w_pend;
            r_skid_instr <= w_skid_instr;
            r_skid_pc    <= w_skid_pc;
            r_pc         <= w_pc;
            r_instr      <= w_instr;
            r_valid      <= w_valid;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a latency-programmable memory model,
// plus a second instance fetching across the 32-bit address wrap.
module tb_fetch_unit;
    localparam logic [31:0] DK = 32'h8CA5_5A00;
    localparam logic [31:0] PC2 = 32'hFFFF_FFF8;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        imem_req, imem_ack, stall, redirect;
    logic [31:0] imem_addr, imem_rdata, redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc, if_instr;
    logic [5:0]  if_op;
    logic [4:0]  if_rs, if_rt, if_rd;
    logic [15:0] if_imm;
    logic        req2, valid2;
    logic [31:0] addr2, pc2, instr2;
    logic [5:0]  op2;
    logic [4:0]  rs2, rt2, rd2;
    logic [15:0] imm2;
    int          lat = 0, cnt = 0, n_tests = 0, n_fail = 0;
    logic [31:0] e;
    always #5 clk = ~clk;
    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .if_op(if_op), .if_rs(if_rs), .if_rt(if_rt), .if_rd(if_rd), .if_imm(if_imm)
    );
    fetch_unit #(.PC_RESET(PC2)) dut2 (
        .clk(clk), .rst_n(rst_n), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(req2), .imem_rdata(addr2), .stall(1'b0), .redirect(1'b0),
        .redirect_pc(32'h0), .if_valid(valid2), .if_pc(pc2), .if_instr(instr2),
        .if_op(op2), .if_rs(rs2), .if_rt(rt2), .if_rd(rd2), .if_imm(imm2)
    );
    // Memory acks once a request has been held for lat cycles.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= 0;
        else cnt <= (imem_req && !imem_ack) ? cnt + 1 : 0;
    assign imem_ack   = imem_req && (cnt >= lat);
    assign imem_rdata = imem_addr ^ DK;
    function automatic logic [31:0] d(input logic [31:0] a);
        return a ^ DK;
    endfunction
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic rst(input int l);
        @(negedge clk);
        rst_n = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        lat = l;
        #1;
        chk("rst req", {31'b0, imem_req}, 32'd0);
        chk("rst addr", imem_addr, 32'd0);
        chk("rst valid", {31'b0, if_valid}, 32'd0);
        chk("rst pc", if_pc, 32'd0);
        chk("rst instr", if_instr, 32'd0);
        chk("rst addr2", addr2, PC2);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask
    initial begin
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        // zero-wait streaming, field slices, and wrap on the second instance
        rst(0);
        for (int k = 0; k < 6; k++) begin
            chk("t1 req", {31'b0, imem_req}, 32'd1);
            chk("t1 addr", imem_addr, 32'(4 * k));
            chk("t1 valid", {31'b0, if_valid}, (k > 0) ? 32'd1 : 32'd0);
            if (k > 0) begin
                e = d(32'(4 * (k - 1)));
                chk("t1 pc", if_pc, 32'(4 * (k - 1)));
                chk("t1 instr", if_instr, e);
                chk("t1 op", {26'b0, if_op}, {26'b0, e[31:26]});
                chk("t1 rs", {27'b0, if_rs}, {27'b0, e[25:21]});
                chk("t1 rt", {27'b0, if_rt}, {27'b0, e[20:16]});
                chk("t1 rd", {27'b0, if_rd}, {27'b0, e[15:11]});
                chk("t1 imm", {16'b0, if_imm}, {16'b0, e[15:0]});
            end
            if (k < 4) begin
                chk("t6 addr2", addr2, PC2 + 32'(4 * k));
                if (k > 0) chk("t6 pc2", pc2, PC2 + 32'(4 * (k - 1)));
            end
            @(negedge clk);
        end
        // stall for three edges with ack every cycle: one word lands in skid
        rst(0);
        @(negedge clk);
        chk("t2 pc0", if_pc, 32'd0);
        stall = 1'b1;
        @(negedge clk);
        chk("t2 req drop", {31'b0, imem_req}, 32'd0);
        chk("t2 hold pc", if_pc, 32'd0);
        chk("t2 addr", imem_addr, 32'd8);
        @(negedge clk);
        @(negedge clk);
        chk("t2 req still", {31'b0, imem_req}, 32'd0);
        chk("t2 hold pc2", if_pc, 32'd0);
        stall = 1'b0;
        @(negedge clk);
        chk("t2 skid pc", if_pc, 32'd4);
        chk("t2 skid instr", if_instr, d(32'd4));
        chk("t2 req back", {31'b0, imem_req}, 32'd1);
        chk("t2 addr8", imem_addr, 32'd8);
        @(negedge clk);
        chk("t2 pc8", if_pc, 32'd8);
        chk("t2 valid", {31'b0, if_valid}, 32'd1);
        @(negedge clk);
        chk("t2 pc12", if_pc, 32'd12);
        // two-cycle ack delay
        rst(2);
        for (int j = 1; j <= 9; j++) begin
            chk("t3 addr", imem_addr, 32'(4 * ((j - 1) / 3)));
            chk("t3 valid", {31'b0, if_valid}, (j >= 4 && (j - 1) % 3 == 0) ? 32'd1 : 32'd0);
            if (j >= 4 && (j - 1) % 3 == 0) chk("t3 pc", if_pc, 32'(4 * ((j - 4) / 3)));
            @(negedge clk);
        end
        // redirect while the fetch of 8 is outstanding
        rst(0);
        @(negedge clk);
        @(negedge clk);
        chk("t4 addr8", imem_addr, 32'd8);
        lat = 3;
        redirect = 1'b1;
        redirect_pc = 32'h40;
        @(negedge clk);
        redirect = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("t4 kill req", {31'b0, imem_req}, 32'd1);
            chk("t4 kill addr", imem_addr, 32'd8);
            chk("t4 kill valid", {31'b0, if_valid}, 32'd0);
            @(negedge clk);
        end
        chk("t4 new addr", imem_addr, 32'h40);
        chk("t4 no wrong", {31'b0, if_valid}, 32'd0);
        lat = 0;
        @(negedge clk);
        chk("t4 pc40", if_pc, 32'h40);
        chk("t4 instr40", if_instr, d(32'h40));
        chk("t4 valid40", {31'b0, if_valid}, 32'd1);
        // redirect in FULL, then redirect coincident with ack
        rst(0);
        @(negedge clk);
        stall = 1'b1;
        @(negedge clk);
        chk("t5 full", {31'b0, imem_req}, 32'd0);
        redirect = 1'b1;
        redirect_pc = 32'h43;
        @(negedge clk);
        redirect = 1'b0;
        stall = 1'b0;
        chk("t5 flush valid", {31'b0, if_valid}, 32'd0);
        chk("t5 addr40", imem_addr, 32'h40);
        @(negedge clk);
        chk("t5 pc40", if_pc, 32'h40);
        chk("t5 addr44", imem_addr, 32'h44);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        redirect = 1'b0;
        chk("t5 ack flush", {31'b0, if_valid}, 32'd0);
        chk("t5 addr100", imem_addr, 32'h100);
        @(negedge clk);
        chk("t5 pc100", if_pc, 32'h100);
        chk("t5 addr104", imem_addr, 32'h104);
        // asynchronous reset in the middle of streaming
        rst(0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
